clk_div_multi: RTL and testbench

// - NCH-channel programmable clock divider.
// - Each channel produces:
//   - a 50%-duty square wave, slow_clk;
//   - a one-cycle tick, a clock enable aligned to each slow_clk rising edge.
// - Sits between the board clock and the slow consumers (display scan, debounce, blink logic).

---
 rtl/clk_div_multi.sv | 100 ++++++++++
 tb/tb_clk_div_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// NCH-channel programmable clock divider: 50%-duty slow_clk plus a rise-aligned tick per channel.
// Optional CLKDIV_SYNC_EN adds a global `sync` input that phase-aligns every channel.
module clk_div_multi #(
  parameter int NCH      = 4,
  parameter int CW       = 24,
  parameter int DIV_INIT = 3,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] en,
  input  logic           div_wr,
  input  logic [SW-1:0]  div_sel,
  input  logic [CW-1:0]  div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] slow_clk,
  output logic [NCH-1:0] tick
);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  act_q [NCH];
  logic [CW-1:0]  act_d [NCH];
  logic [CW-1:0]  shd_q [NCH];
  logic [CW-1:0]  shd_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] slow_q, slow_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] load;

`ifdef CLKDIV_SYNC_EN
  assign stop = ~en | {NCH{sync}};
`else
  assign stop = ~en;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    slow_d = slow_q;
    tick_d = '0;
    load   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (stop[i]) begin
        cnt_d[i]  = '0;
        slow_d[i] = 1'b0;
        load[i]   = pend_q[i];
      end else if (cnt_q[i] == act_q[i]) begin
        cnt_d[i]  = '0;
        slow_d[i] = ~slow_q[i];
        tick_d[i] = ~slow_q[i];
        load[i]   = pend_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (load[i]) begin
        act_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
      end
      // A write in the same cycle overrides the pend clear; the load above used the old shadow.
      if (div_wr && (div_sel == SW'(i))) begin
        shd_d[i]  = div_val;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= CW'(DIV_INIT);
        shd_q[i] <= CW'(DIV_INIT);
      end
      pend_q <= '0;
      slow_q <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q <= pend_d;
      slow_q <= slow_d;
      tick_q <= tick_d;
    end
  end

  assign pend     = pend_q;
  assign slow_clk = slow_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi (NCH=4, CW=8, DIV_INIT=3): a countdown reference model
// pushes expected outputs per edge; a monitor pops and compares after each rising edge.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = '0;
  logic       div_wr = 1'b0;
  logic [1:0] div_sel = '0;
  logic [7:0] div_val = '0;
  logic [3:0] pend, slow_clk, tick;

  clk_div_multi #(.NCH(4), .CW(8), .DIV_INIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_wr(div_wr), .div_sel(div_sel),
    .div_val(div_val), .pend(pend), .slow_clk(slow_clk), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] slow;
    logic [3:0] tick;
    logic [3:0] pend;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: edges remaining until the next toggle, plus divisor/shadow bookkeeping.
  int         m_act[4], m_shd[4], m_rem[4];
  logic [3:0] m_slow, m_tick, m_pend;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 3; m_shd[i] = 3; m_rem[i] = 4;
    end
    m_slow = '0; m_tick = '0; m_pend = '0;
  endtask

  task automatic model_edge(input logic [3:0] e, input logic w, input logic [1:0] s,
                            input logic [7:0] v);
    for (int i = 0; i < 4; i++) begin
      bit boundary = 0;
      m_tick[i] = 1'b0;
      if (!e[i]) begin
        m_slow[i] = 1'b0;
        boundary = 1;
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_tick[i] = !m_slow[i];
          m_slow[i] = !m_slow[i];
          boundary = 1;
        end
      end
      if (boundary && m_pend[i]) begin
        m_act[i] = m_shd[i];
        m_pend[i] = 1'b0;
      end
      if (boundary) m_rem[i] = m_act[i] + 1;
      if (w && (int'(s) == i)) begin
        m_shd[i] = int'(v);
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [3:0] e, input logic w, input logic [1:0] s,
                      input logic [7:0] v);
    @(negedge clk);
    en = e; div_wr = w; div_sel = s; div_val = v;
    model_edge(e, w, s, v);
    q.push_back('{slow: m_slow, tick: m_tick, pend: m_pend});
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    en = '0; div_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_slow", int'(slow_clk), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pend", int'(pend), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({slow_clk, tick, pend} !== e) begin
          n_bad++;
          $display("FAIL edge_out @%0t: slow/tick/pend got %b/%b/%b expected %b/%b/%b",
                   $time, slow_clk, tick, pend, e.slow, e.tick, e.pend);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int first;
    model_reset();
    #1;
    chk("init_slow", int'(slow_clk), 0);
    chk("init_pend", int'(pend), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0 alone: first rise on the 4th enabled edge.
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(4'b0001, 1'b0, 2'd0, 8'd0);
      settle();
      if (tick[0]) first = k;
    end
    chk("s1_first_tick", first, 4);
    repeat (20) step(4'b0001, 1'b0, 2'd0, 8'd0);

    // Channel 1: write div 0 at cnt=1; pend holds until the TC at cnt=3.
    do_reset();
    step(4'b0010, 1'b0, 2'd0, 8'd0);
    step(4'b0010, 1'b1, 2'd1, 8'd0);
    settle();
    chk("s2_pend_set", int'(pend[1]), 1);
    step(4'b0010, 1'b0, 2'd0, 8'd0);
    settle();
    chk("s2_pend_hold", int'(pend[1]), 1);
    step(4'b0010, 1'b0, 2'd0, 8'd0);
    settle();
    chk("s2_pend_clr", int'(pend[1]), 0);
    repeat (10) step(4'b0010, 1'b0, 2'd0, 8'd0);

    // Channel 2: writes 5 then 1, then 7 coinciding with TC.
    do_reset();
    step(4'b0100, 1'b1, 2'd2, 8'd5);
    step(4'b0100, 1'b1, 2'd2, 8'd1);
    step(4'b0100, 1'b0, 2'd0, 8'd0);
    step(4'b0100, 1'b1, 2'd2, 8'd7);
    settle();
    chk("s3_tc_tick", int'(tick[2]), 1);
    chk("s3_pend_kept", int'(pend[2]), 1);
    step(4'b0100, 1'b0, 2'd0, 8'd0);
    step(4'b0100, 1'b0, 2'd0, 8'd0);
    settle();
    chk("s3_second_tc_fall", int'(slow_clk[2]), 0);
    chk("s3_pend_clr", int'(pend[2]), 0);
    repeat (40) step(4'b0100, 1'b0, 2'd0, 8'd0);

    // Channel 0 disabled while high, then re-enabled.
    do_reset();
    repeat (5) step(4'b0001, 1'b0, 2'd0, 8'd0);
    settle();
    chk("s4_high_before", int'(slow_clk[0]), 1);
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    settle();
    chk("s4_low_after", int'(slow_clk[0]), 0);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(4'b0001, 1'b0, 2'd0, 8'd0);
      settle();
      if (tick[0]) first = k;
    end
    chk("s4_reenable_first_tick", first, 4);
    repeat (20) step(4'b0001, 1'b0, 2'd0, 8'd0);

    // Extremes: ch3 at the maximum divisor, ch0 at divide-by-2.
    do_reset();
    step(4'b1001, 1'b1, 2'd3, 8'd255);
    step(4'b1001, 1'b1, 2'd0, 8'd0);
    repeat (1100) step(4'b1001, 1'b0, 2'd0, 8'd0);

    // Randomised traffic.
    do_reset();
    begin
      logic [3:0] re;
      re = 4'($urandom);
      for (int k = 0; k < 3000; k++) begin
        logic       w;
        logic [7:0] v;
        if ($urandom_range(0, 39) == 0) re = 4'($urandom);
        w = ($urandom_range(0, 4) == 0);
        v = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
        step(re, w, 2'($urandom), v);
        if (k == 1500) begin
          settle();
          do_reset();
        end
      end
    end

    @(negedge clk);
    div_wr = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
